// File: rtl/tt_um_serial_subtractor_christ.sv
// rtl/tt_um_serial_subtractor_christ.sv - bit-serial 6-bit subtractor tile, D = A - B, LSB first
module tt_um_serial_subtractor_christ #(
    parameter int WIDTH = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             start_q;
    logic             start_edge;
    logic             load;
    logic             last_bit;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] d_sh;
    logic [WIDTH-1:0] d_sh_next;
    logic [WIDTH-1:0] d_out;
    logic             br;
    logic             br_next;
    logic             d_bit;
    logic             borrow_out;
    logic             done;
    logic [CW-1:0]    cnt;
    logic             unused_ok;

    // ena and the spare input bits carry no function in this tile
    assign unused_ok = &{1'b0, ena, ui_in[6], uio_in[7:6]};

    assign start_edge = ui_in[7] & ~start_q;

    // One full-subtractor bit per clock; the difference bit enters d_sh at the MSB
    always_comb begin
        d_bit     = a_sh[0] ^ b_sh[0] ^ br;
        br_next   = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
        d_sh_next = {d_bit, d_sh[WIDTH-1:1]};
    end

    // Next-state logic: a start edge loads from IDLE/DONE, RUN ends after WIDTH bits
    always_comb begin
        state_next = state;
        load       = 1'b0;
        last_bit   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start_edge) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    last_bit   = 1'b1;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand shifters, borrow flop, bit counter and committed result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_q    <= 1'b1;
            a_sh       <= '0;
            b_sh       <= '0;
            d_sh       <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            d_out      <= '0;
            borrow_out <= 1'b0;
            done       <= 1'b0;
        end else begin
            start_q <= ui_in[7];
            if (load) begin
                a_sh <= ui_in[WIDTH-1:0];
                b_sh <= uio_in[WIDTH-1:0];
                d_sh <= '0;
                br   <= 1'b0;
                cnt  <= '0;
                done <= 1'b0;
            end else if (state == RUN) begin
                a_sh <= a_sh >> 1;
                b_sh <= b_sh >> 1;
                d_sh <= d_sh_next;
                br   <= br_next;
                cnt  <= cnt + CW'(1);
                if (last_bit) begin
                    d_out      <= d_sh_next;
                    borrow_out <= br_next;
                    done       <= 1'b1;
                end
            end
        end
    end

    assign uo_out  = {done, borrow_out, d_out};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule
